// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD feeder and the GCD core environment.
package gcd_pkg;

    localparam int unsigned GCD_WIDTH = 16;

    // Feeder control states; 3-bit encoding kept stable for external probes.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_WAIT   = 3'd3,
        ST_CLEAR  = 3'd4,
        ST_OUT    = 3'd5
    } feeder_state_t;

    // Operand pair as carried between producer, feeder and core benches.
    typedef struct packed {
        logic [GCD_WIDTH-1:0] a;
        logic [GCD_WIDTH-1:0] b;
    } gcd_pair_t;

endpackage

// File: rtl/gcd_pair_fifo.sv
// Synchronous operand-pair FIFO with full/empty flags and an occupancy count.
// Read data is the current head (show-ahead), valid whenever empty_o is low.
module gcd_pair_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wr_a_i,
    input  logic [WIDTH-1:0]         wr_b_i,
    output logic [WIDTH-1:0]         rd_a_o,
    output logic [WIDTH-1:0]         rd_b_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_a_q [DEPTH];
    logic [WIDTH-1:0] mem_b_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == FULL_COUNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rd_a_o  = mem_a_q[rd_ptr_q];
    assign rd_b_o  = mem_b_q[rd_ptr_q];

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_a_q[wr_ptr_q] <= wr_a_i;
            mem_b_q[wr_ptr_q] <= wr_b_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Occupancy: simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/gcd_operand_feeder.sv
// Operand feeder for the subtractive GCD core: buffers pairs, drives the
// core's two-cycle A/B load, waits for done, clears the core and presents
// the result. Pairs containing a zero bypass the core entirely, since the
// subtractive algorithm never terminates when exactly one operand is zero.
module gcd_operand_feeder
    import gcd_pkg::*;
#(
    parameter int unsigned WIDTH = GCD_WIDTH,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             gcd_start,
    output logic [WIDTH-1:0] gcd_data,
    output logic             gcd_clr,
    input  logic             gcd_done,
    input  logic [WIDTH-1:0] gcd_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_gcd,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    feeder_state_t    state_q;
    feeder_state_t    state_d;
    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_b_q;
    logic [WIDTH-1:0] out_gcd_q;
    logic [WIDTH-1:0] out_a_q;
    logic [WIDTH-1:0] out_b_q;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic [WIDTH-1:0] head_a;
    logic [WIDTH-1:0] head_b;
    logic             head_bypass;

    assign in_ready    = (fifo_count != FULL_COUNT);
    assign fifo_push   = in_valid && !fifo_full;
    assign fifo_pop    = (state_q == ST_IDLE) && !fifo_empty;
    assign head_bypass = (head_a == '0) || (head_b == '0);

    gcd_pair_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wr_a_i  (in_a),
        .wr_b_i  (in_b),
        .rd_a_o  (head_a),
        .rd_b_o  (head_b),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Next-state decode; gcd_done only matters while waiting on the core.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (!fifo_empty) state_d = head_bypass ? ST_OUT : ST_LOAD_A;
            ST_LOAD_A: state_d = ST_LOAD_B;
            ST_LOAD_B: state_d = ST_WAIT;
            ST_WAIT:   if (gcd_done) state_d = ST_CLEAR;
            ST_CLEAR:  state_d = ST_OUT;
            ST_OUT:    if (out_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Capture the popped pair for the core load and the output echo.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a_q <= '0;
            op_b_q <= '0;
        end else if (fifo_pop) begin
            op_a_q <= head_a;
            op_b_q <= head_b;
        end
    end

    // Result registers: loaded from the bypass path or from the core, then
    // held untouched through OUT until the next pair completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_gcd_q <= '0;
            out_a_q   <= '0;
            out_b_q   <= '0;
        end else if (fifo_pop && head_bypass) begin
            out_gcd_q <= head_a | head_b;
            out_a_q   <= head_a;
            out_b_q   <= head_b;
        end else if ((state_q == ST_WAIT) && gcd_done) begin
            out_gcd_q <= gcd_result;
            out_a_q   <= op_a_q;
            out_b_q   <= op_b_q;
        end
    end

    // Core-facing and result outputs decode from registered state only.
    always_comb begin
        gcd_data = '0;
        unique case (state_q)
            ST_LOAD_A: gcd_data = op_a_q;
            ST_LOAD_B: gcd_data = op_b_q;
            default:   gcd_data = '0;
        endcase
    end

    assign gcd_start = (state_q == ST_LOAD_A);
    assign gcd_clr   = (state_q == ST_CLEAR);
    assign out_valid = (state_q == ST_OUT);
    assign out_gcd   = out_gcd_q;
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;

endmodule

// File: tb/tb_gcd_operand_feeder.sv
// Directed bench for gcd_operand_feeder with a behavioural subtractive-GCD core.
module tb_gcd_operand_feeder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        gcd_start;
    logic [15:0] gcd_data;
    logic        gcd_clr;
    logic        gcd_done;
    logic [15:0] gcd_result;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_gcd;
    logic [15:0] out_a;
    logic [15:0] out_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gcd_operand_feeder #(.WIDTH(16), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .gcd_start  (gcd_start),
        .gcd_data   (gcd_data),
        .gcd_clr    (gcd_clr),
        .gcd_done   (gcd_done),
        .gcd_result (gcd_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_gcd    (out_gcd),
        .out_a      (out_a),
        .out_b      (out_b)
    );

    // Behavioural core: A on start, B the next cycle, done a few cycles later,
    // held until the clear pulse. stray_done injects done outside a run.
    logic [15:0] core_a, core_b, core_res;
    logic        core_done;
    logic        stray_done = 1'b0;
    int          core_phase;
    int          core_cnt;

    function automatic logic [15:0] euclid(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x, y, t;
        x = a; y = b;
        while (y != 0) begin t = x % y; x = y; y = t; end
        return x;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            core_done <= 1'b0; core_phase <= 0; core_cnt <= 0;
            core_a <= '0; core_b <= '0; core_res <= '0;
        end else if (gcd_clr) begin
            core_done <= 1'b0; core_phase <= 0;
        end else if (gcd_start) begin
            core_a <= gcd_data; core_phase <= 1;
        end else if (core_phase == 1) begin
            core_b <= gcd_data; core_phase <= 2; core_cnt <= 4;
        end else if (core_phase == 2) begin
            if (core_cnt == 0) begin
                core_done <= 1'b1; core_res <= euclid(core_a, core_b); core_phase <= 3;
            end else begin
                core_cnt <= core_cnt - 1;
            end
        end
    end

    assign gcd_done   = core_done | stray_done;
    assign gcd_result = core_res;

    task automatic test_reset();
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if ({gcd_start, gcd_clr} !== 2'b00) begin errors++; $display("FAIL reset_start_clr got %b exp 00", {gcd_start, gcd_clr}); end
        checks++; if (gcd_data !== 16'd0) begin errors++; $display("FAIL reset_gcd_data got %0d exp 0", gcd_data); end
        checks++; if ({out_gcd, out_a, out_b} !== 48'd0) begin errors++; $display("FAIL reset_out_regs got %0d/%0d/%0d exp 0/0/0", out_gcd, out_a, out_b); end
        @(posedge clk); #1; rst = 1'b0;
    endtask

    task automatic test_basic();
        int done_cyc = -1;
        int clr_cnt = 0;
        int cyc = 4;
        bit got = 0;
        @(posedge clk); #1; in_valid = 1; in_a = 16'd48; in_b = 16'd18; out_ready = 0;
        @(posedge clk); #1; in_valid = 0;
        @(negedge clk);
        checks++; if (gcd_start !== 1'b0) begin errors++; $display("FAIL basic_c1_start got %b exp 0", gcd_start); end
        @(negedge clk);
        checks++; if (gcd_start !== 1'b1 || gcd_data !== 16'd48) begin errors++; $display("FAIL basic_load_a got start=%b data=%0d exp 1/48", gcd_start, gcd_data); end
        @(negedge clk);
        checks++; if (gcd_start !== 1'b0 || gcd_data !== 16'd18) begin errors++; $display("FAIL basic_load_b got start=%b data=%0d exp 0/18", gcd_start, gcd_data); end
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (gcd_done && done_cyc < 0) done_cyc = cyc;
            if (gcd_clr) clr_cnt++;
            if (out_valid) got = 1; else cyc++;
        end
        checks++; if (!got) begin errors++; $display("FAIL basic_timeout got no out_valid exp out_valid"); end
        checks++; if (cyc !== done_cyc + 2) begin errors++; $display("FAIL basic_latency got cycle %0d exp %0d", cyc, done_cyc + 2); end
        checks++; if (out_gcd !== 16'd6 || out_a !== 16'd48 || out_b !== 16'd18) begin errors++; $display("FAIL basic_result got %0d/%0d/%0d exp 6/48/18", out_gcd, out_a, out_b); end
        out_ready = 1;
        @(posedge clk); #1; out_ready = 0;
        for (int i = 0; i < 4; i++) begin @(negedge clk); if (gcd_clr) clr_cnt++; end
        checks++; if (clr_cnt !== 1) begin errors++; $display("FAIL basic_clr_pulses got %0d exp 1", clr_cnt); end
    endtask

    task automatic test_zero_bypass();
        int core_touch = 0;
        @(posedge clk); #1; stray_done = 1; out_ready = 1; in_valid = 1; in_a = 16'd0; in_b = 16'd7;
        @(posedge clk); #1; in_a = 16'd0; in_b = 16'd0;
        @(negedge clk); if (gcd_start || gcd_clr) core_touch++;
        @(posedge clk); #1; in_valid = 0;
        @(negedge clk); if (gcd_start || gcd_clr) core_touch++;
        checks++; if (out_valid !== 1'b1 || out_gcd !== 16'd7 || out_a !== 16'd0 || out_b !== 16'd7) begin errors++; $display("FAIL bypass_first got v=%b %0d/%0d/%0d exp 1 7/0/7", out_valid, out_gcd, out_a, out_b); end
        @(negedge clk); if (gcd_start || gcd_clr) core_touch++;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bypass_gap got %b exp 0", out_valid); end
        @(negedge clk); if (gcd_start || gcd_clr) core_touch++;
        checks++; if (out_valid !== 1'b1 || out_gcd !== 16'd0 || out_a !== 16'd0 || out_b !== 16'd0) begin errors++; $display("FAIL bypass_second got v=%b %0d/%0d/%0d exp 1 0/0/0", out_valid, out_gcd, out_a, out_b); end
        @(posedge clk); #1; out_ready = 0; stray_done = 0;
        for (int i = 0; i < 3; i++) begin @(negedge clk); if (gcd_start || gcd_clr || out_valid) core_touch++; end
        checks++; if (core_touch !== 0) begin errors++; $display("FAIL bypass_core_touch got %0d exp 0", core_touch); end
    endtask

    task automatic test_full_fifo();
        logic [15:0] pa [6];
        logic [15:0] pb [6];
        int nres = 0;
        bit acc;
        pa = '{16'd12, 16'd8, 16'd4, 16'd20, 16'd28, 16'd16};
        pb = '{16'd8, 16'd12, 16'd4, 16'd8, 16'd12, 16'd36};
        @(posedge clk); #1; out_ready = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1; in_a = pa[i]; in_b = pb[i];
            @(negedge clk);
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_accept%0d got in_ready %b exp 1", i, in_ready); end
            @(posedge clk); #1;
        end
        in_a = pa[5]; in_b = pb[5];
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready_drop got %b exp 0", in_ready); end
        repeat (15) @(negedge clk);
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL full_hold got in_ready=%b out_valid=%b exp 0/1", in_ready, out_valid); end
        @(posedge clk); #1; out_ready = 1;
        for (int c = 0; c < 300 && nres < 6; c++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            if (out_valid) begin
                checks++;
                if (out_gcd !== 16'd4 || out_a !== pa[nres] || out_b !== pb[nres]) begin
                    errors++; $display("FAIL full_result%0d got %0d/%0d/%0d exp 4/%0d/%0d", nres, out_gcd, out_a, out_b, pa[nres], pb[nres]);
                end
                nres++;
            end
            @(posedge clk); #1;
            if (acc) in_valid = 0;
        end
        out_ready = 0;
        checks++; if (nres !== 6 || in_valid !== 1'b0) begin errors++; $display("FAIL full_count got %0d results pending=%b exp 6 pending=0", nres, in_valid); end
    endtask

    task automatic test_backpressure();
        bit got = 0;
        @(posedge clk); #1; out_ready = 0; in_valid = 1; in_a = 16'd9; in_b = 16'd9;
        @(posedge clk); #1; in_valid = 0;
        for (int i = 0; i < 40 && !got; i++) begin @(negedge clk); got = out_valid; end
        checks++; if (!got) begin errors++; $display("FAIL bp_timeout got no out_valid exp out_valid"); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b1 || out_gcd !== 16'd9 || gcd_start !== 1'b0) begin errors++; $display("FAIL bp_hold%0d got v=%b gcd=%0d start=%b exp 1/9/0", i, out_valid, out_gcd, gcd_start); end
        end
        out_ready = 1;
        @(posedge clk); #1; out_ready = 0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release got %b exp 0", out_valid); end
    endtask

    task automatic test_reset_in_wait();
        int stray = 0;
        @(posedge clk); #1; in_valid = 1; in_a = 16'd30; in_b = 16'd12;
        @(posedge clk); #1; in_a = 16'd40; in_b = 16'd15;
        @(posedge clk); #1; in_a = 16'd14; in_b = 16'd21;
        @(posedge clk); #1; in_valid = 0;
        @(posedge clk); #1;
        checks++; if (dut.u_fifo.count_o !== 3'd2 || gcd_start !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL rw_pre count=%0d start=%b v=%b exp 2/0/0", dut.u_fifo.count_o, gcd_start, out_valid); end
        rst = 1;
        #2;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || dut.u_fifo.count_o !== 3'd0) begin errors++; $display("FAIL rw_flush got ready=%b v=%b count=%0d exp 1/0/0", in_ready, out_valid, dut.u_fifo.count_o); end
        @(posedge clk); #1; rst = 0; out_ready = 1;
        for (int i = 0; i < 30; i++) begin @(negedge clk); if (out_valid || gcd_start || gcd_clr) stray++; end
        out_ready = 0;
        checks++; if (stray !== 0) begin errors++; $display("FAIL rw_no_output got %0d active cycles exp 0", stray); end
    endtask

    task automatic test_same_cycle_push_pop();
        logic [15:0] ea [2];
        logic [15:0] eb [2];
        logic [15:0] eg [2];
        int nres = 0;
        ea = '{16'd15, 16'd21}; eb = '{16'd10, 16'd14}; eg = '{16'd5, 16'd7};
        @(posedge clk); #1; out_ready = 0; in_valid = 1; in_a = ea[0]; in_b = eb[0];
        @(posedge clk); #1; in_a = ea[1]; in_b = eb[1];
        @(negedge clk);
        checks++; if (dut.u_fifo.count_o !== 3'd1) begin errors++; $display("FAIL sc_count_before got %0d exp 1", dut.u_fifo.count_o); end
        @(posedge clk); #1; in_valid = 0;
        @(negedge clk);
        checks++; if (dut.u_fifo.count_o !== 3'd1) begin errors++; $display("FAIL sc_count_after got %0d exp 1", dut.u_fifo.count_o); end
        out_ready = 1;
        for (int c = 0; c < 100 && nres < 2; c++) begin
            if (c != 0) @(negedge clk);
            if (out_valid) begin
                checks++;
                if (out_gcd !== eg[nres] || out_a !== ea[nres] || out_b !== eb[nres]) begin
                    errors++; $display("FAIL sc_order%0d got %0d/%0d/%0d exp %0d/%0d/%0d", nres, out_gcd, out_a, out_b, eg[nres], ea[nres], eb[nres]);
                end
                nres++;
            end
        end
        @(posedge clk); #1; out_ready = 0;
        checks++; if (nres !== 2) begin errors++; $display("FAIL sc_count_results got %0d exp 2", nres); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_bypass();
        test_full_fifo();
        test_backpressure();
        test_reset_in_wait();
        test_same_cycle_push_pop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gcd_operand_feeder.md
# gcd_operand_feeder

Upstream feeder for the subtractive GCD core. Accepts operand pairs over a valid/ready handshake and buffers them in a small FIFO. Drives the core's serial two-cycle load sequence (A, then B), waits for `done`, and returns the result with a valid/ready output. Zero operands bypass the core, because subtractive GCD never terminates when exactly one operand is 0.

## Interface
- `WIDTH`, 16, operand/result width; matches the core's data bus.
- `DEPTH`, 4, operand FIFO entries; power of two, ≥2.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operand pair present.
- `in_ready`  out  1  FIFO can accept; equals !full.
- `in_a`, `in_b`  in  WIDTH  operands.
- `gcd_start`  out  1  core start; high only in LOAD_A.
- `gcd_data`  out  WIDTH  core `data_in`: A in LOAD_A, B in LOAD_B, else 0.
- `gcd_clr`  out  1  one-cycle core re-init pulse after each core run.
- `gcd_done`  in  1  core finished (level).
- `gcd_result`  in  WIDTH  core A register; valid while `gcd_done`.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts.
- `out_gcd`, `out_a`, `out_b`  out  WIDTH  result plus echoed operands.

## Operation
- **FIFO**
  - Push when `in_valid && in_ready`. Pop only in IDLE when non-empty.
  - Push and pop in the same cycle are legal; count is unchanged.
  - No push when full, because `in_ready` is low.
  - Pointers wrap modulo DEPTH. Count is `$clog2(DEPTH)+1` bits.
- **FSM states:** IDLE, LOAD_A, LOAD_B, WAIT, CLEAR, OUT.
- **IDLE**
  - Empty FIFO: stay in IDLE.
  - Non-empty: pop the head into `op_a`/`op_b`.
  - If either operand is 0: `res = op_a | op_b` (gcd(x,0)=x, gcd(0,0)=0), go to OUT. The core is never touched.
  - Otherwise: go to LOAD_A.
- **LOAD_A:** `gcd_start=1`, `gcd_data=op_a` → LOAD_B.
- **LOAD_B:** `gcd_data=op_b` → WAIT.
- **WAIT:** when `gcd_done`, capture `res=gcd_result` → CLEAR. No timeout.
- **CLEAR:** `gcd_clr=1` for one cycle → OUT.
- **OUT**
  - `out_valid=1`. `out_gcd/out_a/out_b` are registered and hold stable until the handshake.
  - On `out_ready` → IDLE.
- A `gcd_done` seen outside WAIT is ignored.
- **Reset values:** `in_ready=1` (FIFO empty). `out_valid`, `gcd_start`, `gcd_clr` = 0. `gcd_data`, `out_*` = 0. State = IDLE.
- **Reset mid-operation:** the FIFO is flushed and any in-flight pair is dropped. `gcd_clr` is not issued by reset; the core shares `rst`.

## Timing
- Cycle 0: input handshake. Cycle 1: pop (IDLE). Cycle 2: LOAD_A. Cycle 3: LOAD_B. Cycle 4 onward: WAIT.
- `gcd_done` seen in cycle k → CLEAR in k+1 → `out_valid` in k+2.
- Bypass path: `out_valid` in cycle 2.
- Back-to-back pairs: the next pop occurs in the cycle after the output handshake, since IDLE is entered then.
- Throughput is one pair in flight. The FIFO absorbs up to DEPTH further pairs.
- All outputs are registered or decoded from state only. There is no combinational path from `in_valid` or `out_ready` to any output except `in_ready` (a function of count).

## Structure
- **Shared package `gcd_pkg`:**
  - State enum `feeder_state_t` (6 states, 3-bit).
  - `GCD_WIDTH=16`.
  - `gcd_pair_t` struct {a, b}, reused by the core testbench.
- **Sub-module `gcd_pair_fifo`:** parameterised WIDTH/DEPTH, synchronous FIFO, `full`/`empty`/`count`.
- **FSM, operand/result registers and bypass logic** live in `gcd_operand_feeder`. Target size is about 200–300 lines total.

## Test plan
- **Basic run:** push (48,18) with a behavioural core model → `gcd_start` high in cycle 2, `gcd_data`=48 then 18, `out_gcd`=6, `out_a`=48, `out_b`=18, one `gcd_clr` pulse.
- **Zero bypass:** push (0,7) then (0,0) → `out_gcd`=7 then 0, each at cycle 2 after its pop. `gcd_start` and `gcd_clr` never assert.
- **Full FIFO:**
  - Hold `out_ready=0` and push 6 pairs of (12,8) → `in_ready` drops after the FIFO holds 4 with 1 in flight. The 6th pair waits.
  - Release `out_ready` → 6 results of 4, in order, none lost.
- **Backpressure:** push (9,9), hold `out_ready=0` for 10 cycles → `out_valid` stays 1 with `out_gcd`=9 stable. The core is not restarted until after the handshake.
- **Reset in WAIT:** assert `rst` in WAIT with 2 pairs queued → next cycle state is IDLE, `in_ready`=1, `out_valid`=0. No result is emitted for the dropped pairs.
- **Same-cycle push/pop:** with count=1, push while IDLE pops → count stays 1 and order is preserved.
